// File: rtl/bus_seq_unlock.sv
// rtl/bus_seq_unlock.sv - bus-access key sequence unlock with serial ID readout.
// Optional failed-attempt lockout is built when BUS_SEQ_UNLOCK_LOCKOUT_EN is defined.
module bus_seq_unlock #(
  parameter int              AW       = 4,
  parameter int              DEPTH    = 4,
  parameter logic [DEPTH*AW-1:0] KEY  = 16'h9BA2,
  parameter logic [1:0]      BASE     = 2'b01,
  parameter logic [AW-1:0]   RD_CMD   = 4'h6,
  parameter int              ID_W     = 16,
  parameter logic [ID_W-1:0] ID       = 16'hC24B,
  parameter int              MAX_FAIL = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stb,
  input  logic          sser,
  input  logic          br_w,
  input  logic [AW+1:0] ba,
  output logic          sdrd,
  output logic          sdrd_oe,
  output logic [1:0]    state_o,
  output logic          unlocked,
  output logic          locked_out
);

  typedef enum logic [1:0] {SEEK = 2'd0, UNLK = 2'd1, LOCK = 2'd2} state_t;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (ID_W > 1) ? $clog2(ID_W) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(ID_W - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] ptr_q, ptr_d;

`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  logic [FW-1:0] fail_q, fail_d;
`endif

  logic          in_win;
  logic          qual;
  logic [AW-1:0] key_fld;
  logic [AW-1:0] key_exp;
  logic          id_bit;

  assign in_win  = stb & ~sser & (ba[AW+1:AW] == BASE);
  assign qual    = in_win & br_w;
  assign key_fld = ba[AW-1:0];

  always_comb begin
    key_exp = KEY[AW-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == IW'(i)) key_exp = KEY[i*AW +: AW];
    end
  end

  // ID is shifted out MSB first, so ptr=0 selects bit ID_W-1
  always_comb begin
    id_bit = 1'b0;
    for (int i = 0; i < ID_W; i++) begin
      if (ptr_q == PW'(i)) id_bit = ID[ID_W-1-i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEEK;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
    fail_d  = fail_q;
`endif
    case (state_q)
      SEEK: begin
        if (in_win && !br_w) begin
          idx_d = '0;
        end else if (qual) begin
          if (key_fld == key_exp) begin
            if (idx_q == IDX_LAST) begin
              state_d = UNLK;
              idx_d   = '0;
              ptr_d   = '0;
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
              fail_d  = '0;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            // a mismatch that is itself the first key element restarts at idx 1
            idx_d = (key_fld == KEY[AW-1:0]) ? IW'(1) : '0;
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
            if (idx_q != '0) begin
              if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
              if (fail_q + 1'b1 >= FAIL_MAX) begin
                state_d = LOCK;
                idx_d   = '0;
              end
            end
`endif
          end
        end
      end
      UNLK: begin
        if (in_win && !br_w) begin
          state_d = SEEK;
          idx_d   = '0;
          ptr_d   = '0;
        end else if (qual) begin
          if (key_fld == RD_CMD) begin
            if (ptr_q == PTR_LAST) begin
              state_d = SEEK;
              idx_d   = '0;
              ptr_d   = '0;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end else begin
            state_d = SEEK;
            idx_d   = '0;
            ptr_d   = '0;
          end
        end
      end
      LOCK: begin
        state_d = LOCK;
      end
      default: begin
        state_d = SEEK;
        idx_d   = '0;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    sdrd_oe    = 1'b0;
    sdrd       = 1'b0;
    unlocked   = 1'b0;
    locked_out = 1'b0;
    state_o    = state_q;
    case (state_q)
      UNLK: begin
        unlocked = 1'b1;
        sdrd_oe  = qual && (key_fld == RD_CMD);
        sdrd     = sdrd_oe & id_bit;
      end
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
      LOCK:    locked_out = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_seq_unlock.sv
// tb/tb_bus_seq_unlock.sv - directed self-checking bench for bus_seq_unlock.
module tb_bus_seq_unlock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       sser = 1'b1;
  logic       br_w = 1'b0;
  logic [5:0] ba = 6'd0;
  logic       sdrd, sdrd_oe, unlocked, locked_out;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [15:0] ID_EXP = 16'b1100_0010_0100_1011;

  bus_seq_unlock dut (
    .clk(clk), .rst(rst), .stb(stb), .sser(sser), .br_w(br_w), .ba(ba),
    .sdrd(sdrd), .sdrd_oe(sdrd_oe), .state_o(state_o),
    .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [3:0] k, input logic rd, input logic [1:0] win);
    @(negedge clk);
    stb = 1'b1; sser = 1'b0; br_w = rd; ba = {win, k};
    @(posedge clk);
    #1;
    stb = 1'b0; sser = 1'b1; br_w = 1'b0;
  endtask

  task automatic key(input logic [3:0] k);
    bus(k, 1'b1, 2'b01);
  endtask

  task automatic unlock_seq();
    key(4'h2); key(4'hA); key(4'hB); key(4'h9);
  endtask

  // presents one RD_CMD access and checks the combinational data bit before the edge
  task automatic read_bit(input string tag, input logic exp);
    @(negedge clk);
    stb = 1'b1; sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'h6};
    #1;
    chk({tag, "_oe"}, sdrd_oe, 1);
    chk({tag, "_bit"}, sdrd, exp);
    @(posedge clk);
    #1;
    stb = 1'b0; sser = 1'b1; br_w = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_oe", sdrd_oe, 0);
    chk("rst_sdrd", sdrd, 0);
    @(negedge clk); rst = 1'b0;

    key(4'h2); key(4'hA); key(4'hB);
    chk("seq3_state", state_o, 0);
    key(4'h9);
    chk("unlock_state", state_o, 1);
    chk("unlock_flag", unlocked, 1);

    for (int i = 0; i < 16; i++) begin
      read_bit($sformatf("rd%0d", i), ID_EXP[15-i]);
      chk($sformatf("rd%0d_state", i), state_o, (i == 15) ? 0 : 1);
    end
    chk("after_read_oe", sdrd_oe, 0);

    key(4'h2); key(4'hA); key(4'h2); key(4'hA); key(4'hB);
    chk("restart_pre", unlocked, 0);
    key(4'h9);
    chk("restart_unlock", unlocked, 1);

    key(4'h3);
    chk("unlk_other_cmd", state_o, 0);
    @(negedge clk);
    stb = 1'b1; sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'h6};
    #1;
    chk("seek_oe", sdrd_oe, 0);
    @(posedge clk); #1;
    stb = 1'b0; sser = 1'b1; br_w = 1'b0;

    key(4'h2); key(4'hA);
    bus(4'hB, 1'b0, 2'b01);
    key(4'hB); key(4'h9);
    chk("write_abort_state", state_o, 0);
    chk("write_abort_unl", unlocked, 0);

    key(4'h2); key(4'hA);
    bus(4'h5, 1'b1, 2'b10);
    @(negedge clk);
    stb = 1'b0; sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'h7};
    @(negedge clk);
    stb = 1'b1; sser = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    key(4'hB); key(4'h9);
    chk("ignore_other_cycles", unlocked, 1);

    bus(4'h6, 1'b0, 2'b01);
    chk("unlk_write_exit", state_o, 0);

    do_reset();
    unlock_seq();
    for (int i = 0; i < 5; i++) read_bit($sformatf("pre%0d", i), ID_EXP[15-i]);
    @(negedge clk);
    stb = 1'b1; sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'h6};
    #1;
    chk("pre_rst_oe", sdrd_oe, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_unl", unlocked, 0);
    chk("async_rst_oe", sdrd_oe, 0);
    chk("async_rst_sdrd", sdrd, 0);
    @(posedge clk); #1;
    stb = 1'b0; sser = 1'b1; br_w = 1'b0;
    @(negedge clk); rst = 1'b0;
    unlock_seq();
    chk("reunlock", unlocked, 1);
    read_bit("fresh15", 1'b1);
    read_bit("fresh14", 1'b1);
    read_bit("fresh13", 1'b0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      key(4'h2); key(4'h3);
    end
`ifdef BUS_SEQ_UNLOCK_LOCKOUT_EN
    chk("lock_state", state_o, 2);
    chk("lock_flag", locked_out, 1);
    unlock_seq();
    chk("lock_hold", state_o, 2);
    chk("lock_unl", unlocked, 0);
`else
    chk("nolock_state", state_o, 0);
    chk("nolock_flag", locked_out, 0);
    unlock_seq();
    chk("nolock_unlock", state_o, 1);
`endif
    do_reset();
    chk("final_rst_state", state_o, 0);
    chk("final_rst_lock", locked_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_seq_unlock.md
BUS_SEQ_UNLOCK -- requirements
Module: bus_seq_unlock

Interface
REQ-001 SHALL have parameter AW, default 4: width of the key field taken from the bus address.
REQ-002 SHALL have parameter DEPTH, default 4: number of accesses in the key sequence (2..8).
REQ-003 SHALL have parameter KEY, default 16'h9BA2, width DEPTH*AW: element i is KEY[AW*i+AW-1:AW*i], and element 0 is the first one expected.
REQ-004 SHALL have parameter BASE, default 2'b01: window decode value compared against ba[AW+1:AW].
REQ-005 SHALL have parameter RD_CMD, default 4'h6, width AW: key-field value that reads one ID bit; it SHALL differ from KEY element 0.
REQ-006 SHALL have parameters ID_W, default 16, and ID, default 16'hC24B: the identification word shifted out after unlock.
REQ-007 SHALL have parameter MAX_FAIL, default 3: count of failed attempts that causes lockout.
REQ-008 clk  in  1  sole clock; all state updates on its rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 stb  in  1  bus cycle valid for this clock.
REQ-011 sser  in  1  device select, active-low.
REQ-012 br_w  in  1  bus read/write; 1 = read.
REQ-013 ba  in  AW+2  address slice; top two bits are the window, low AW bits are the key field.
REQ-014 sdrd  out  1  serial ID data bit.
REQ-015 sdrd_oe  out  1  drive enable for sdrd.
REQ-016 state_o  out  2  FSM state: 0 SEEK, 1 UNLK, 2 LOCK.
REQ-017 unlocked  out  1  high while in UNLK.
REQ-018 locked_out  out  1  high while in LOCK.

Function
REQ-019 In-window cycle: stb & ~sser & (ba[AW+1:AW]==BASE). Qualified access: an in-window cycle with br_w=1. Every other cycle SHALL hold all state.
REQ-020 SEEK SHALL track an index idx in the range 0..DEPTH-1. A qualified access whose key field equals KEY[idx] SHALL increment idx.
REQ-021 A qualified access that matches KEY[DEPTH-1] SHALL enter UNLK with ptr=0, idx=0 and fail_cnt=0.
REQ-022 A mismatching qualified access in SEEK SHALL set idx to 1 if the key field equals KEY[0], else to 0. If idx was greater than 0 beforehand, fail_cnt SHALL increment.
REQ-023 An in-window cycle with br_w=0 in SEEK or UNLK SHALL force SEEK with idx=0. It SHALL NOT count as a failure.
REQ-024 In UNLK, sdrd_oe SHALL be asserted combinationally while a qualified access with key field RD_CMD is present.
REQ-025 While sdrd_oe is asserted, sdrd SHALL equal ID[ID_W-1-ptr] (MSB first). sdrd SHALL be 0 whenever sdrd_oe=0.
REQ-026 Each RD_CMD access SHALL increment ptr. The access that reads ptr=ID_W-1 SHALL return the FSM to SEEK with idx=0.
REQ-027 A qualified access in UNLK with a key field other than RD_CMD SHALL return to SEEK with idx=0, without counting a failure.
REQ-028 idx, ptr and fail_cnt widths SHALL be clog2-derived; ptr and idx SHALL never exceed their maxima.
REQ-029 sdrd_oe SHALL be 0 in SEEK and LOCK.

Reset
REQ-030 While rst=1, the block SHALL be in state SEEK with idx=0, ptr=0, fail_cnt=0, sdrd=0, sdrd_oe=0, state_o=0, unlocked=0, locked_out=0.
REQ-031 Reset asserted mid-sequence or mid-readout SHALL abandon the operation immediately, with no residual progress.

Configuration
REQ-032 With macro BUS_SEQ_UNLOCK_LOCKOUT_EN defined: fail_cnt saturates at MAX_FAIL; reaching MAX_FAIL enters LOCK; LOCK ignores all bus activity until rst.
REQ-033 Without BUS_SEQ_UNLOCK_LOCKOUT_EN: no fail counter is built, LOCK is unreachable, and locked_out is tied to 0.

Verification
REQ-034 Key accesses 2,A,B,9 with window 01 and br_w=1 -> state_o=1 and unlocked=1 after the fourth edge.
REQ-035 Unlock, then 16 RD_CMD (6) accesses -> sdrd bits 1100_0010_0100_1011 with sdrd_oe=1 on each; state_o=0 after the 16th.
REQ-036 Accesses 2,A,2,A,B,9 -> unlocked after the sixth, because the mismatching 2 restarts at idx=1.
REQ-037 Accesses 2,A then br_w=0 in-window cycle, then B,9 -> remains SEEK, unlocked=0.
REQ-038 With LOCKOUT_EN, three sequences 2,3 -> locked_out=1; a following 2,A,B,9 -> still LOCK; rst pulse -> SEEK.
REQ-039 Unlock, 5 RD_CMD reads, rst asserted asynchronously between edges -> outputs 0 immediately; new unlock and read -> starts at ID bit 15.
